// File: rtl/alarm_trigger_if.sv
// Alarm trigger bus: time inputs, alarm setting, buttons, and ringing/status outputs.
// master drives time, settings and buttons; slave (alarm_trigger) drives status.
// Ports: sec_tick, cur_*, set_*, set_load, arm_en, snooze_btn, stop_btn -> slave;
//        alarm_out, state, alm_hour, alm_min, snooze_left -> master.
interface alarm_trigger_if;
  logic       sec_tick;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic [7:0] cur_sec;
  logic [7:0] set_hour;
  logic [7:0] set_min;
  logic       set_load;
  logic       arm_en;
  logic       snooze_btn;
  logic       stop_btn;
  logic       alarm_out;
  logic [1:0] state;
  logic [7:0] alm_hour;
  logic [7:0] alm_min;
  logic [2:0] snooze_left;

  modport master (
    output sec_tick, cur_hour, cur_min, cur_sec, set_hour, set_min,
           set_load, arm_en, snooze_btn, stop_btn,
    input  alarm_out, state, alm_hour, alm_min, snooze_left
  );

  modport slave (
    input  sec_tick, cur_hour, cur_min, cur_sec, set_hour, set_min,
           set_load, arm_en, snooze_btn, stop_btn,
    output alarm_out, state, alm_hour, alm_min, snooze_left
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm-time register and ringing controller (IDLE / RINGING / SNOOZE) with
// ring timeout, limited snoozes and stop. All outputs registered, 1-cycle latency.
// Ports: clk, rst (sync, active-high), bus (alarm_trigger_if.slave).
module alarm_trigger #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic            clk,
  input  logic            rst,
  alarm_trigger_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  localparam logic [2:0]  MAX_S    = 3'(MAX_SNOOZE);
  localparam logic [10:0] RING_LIM = 11'(RING_SECS);
  localparam logic [10:0] SNZ_LIM  = 11'(SNOOZE_SECS);

  state_t      st, st_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic [10:0] cnt_inc;
  logic [2:0]  snz, snz_nxt;
  logic [7:0]  hour_q, min_q;
  logic        alarm_q;
  logic        match;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

  // Compares against the stored alarm, so a load in the same cycle uses the old value.
  assign match = bus.sec_tick & bus.arm_en & (bus.cur_hour == hour_q) &
                 (bus.cur_min == min_q) & (bus.cur_sec == 8'h00);

  // One bit wider than the counter so the bound check sees the value before it
  // could wrap; reaching the bound always changes state, which clears cnt.
  assign cnt_inc = {1'b0, cnt} + 11'd1;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    snz_nxt = snz;
    if (bus.sec_tick && (st != IDLE)) cnt_nxt = cnt_inc[9:0];
    case (st)
      IDLE: begin
        if (match) begin
          st_nxt  = RINGING;
          snz_nxt = MAX_S;
        end
      end
      RINGING: begin
        if (!bus.arm_en || bus.stop_btn) begin
          st_nxt = IDLE;
        end else if (bus.snooze_btn && (snz != 3'd0)) begin
          st_nxt  = SNOOZE;
          snz_nxt = snz - 3'd1;
        end else if (bus.sec_tick && (cnt_inc == RING_LIM)) begin
          st_nxt = IDLE;
        end
      end
      SNOOZE: begin
        if (!bus.arm_en || bus.stop_btn) begin
          st_nxt = IDLE;
        end else if (bus.sec_tick && (cnt_inc == SNZ_LIM)) begin
          st_nxt = RINGING;
        end
      end
      default: st_nxt = IDLE;
    endcase
    if (st_nxt != st) cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      snz     <= MAX_S;
      hour_q  <= 8'h07;
      min_q   <= 8'h00;
      alarm_q <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      snz     <= snz_nxt;
      alarm_q <= (st_nxt == RINGING);
      // Hour and minute validated independently; a bad field keeps its old value.
      if (bus.set_load && bcd_ok(bus.set_hour, 8'h23)) hour_q <= bus.set_hour;
      if (bus.set_load && bcd_ok(bus.set_min, 8'h59))  min_q  <= bus.set_min;
    end
  end

  assign bus.alarm_out   = alarm_q;
  assign bus.state       = st;
  assign bus.alm_hour    = hour_q;
  assign bus.alm_min     = min_q;
  assign bus.snooze_left = snz;

endmodule

// File: tb/tb_alarm_trigger.sv
// Testbench for alarm_trigger: directed sequences, a load-validation table, and
// randomized stimulus checked every cycle against a countdown-based reference model.
module tb_alarm_trigger;
  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_trigger_if bus();

  alarm_trigger #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: 0 idle, 1 ringing, 2 snoozing; m_left counts ticks remaining.
  int m_st, m_left, m_snz, m_hour, m_min;

  typedef struct {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] eh;
    logic [7:0] em;
  } ld_t;
  ld_t lt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid(input logic [7:0] v, input int maxdec);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= maxdec);
  endfunction

  task automatic model_edge();
    bit mt;
    if (rst) begin
      m_st = 0; m_left = 0; m_snz = MAXS; m_hour = 7; m_min = 0;
      return;
    end
    mt = bus.sec_tick && bus.arm_en && (int'(bus.cur_hour) == m_hour) &&
         (int'(bus.cur_min) == m_min) && (bus.cur_sec == 8'h00);
    if (bus.set_load) begin
      if (valid(bus.set_hour, 23)) m_hour = int'(bus.set_hour);
      if (valid(bus.set_min, 59))  m_min  = int'(bus.set_min);
    end
    if (m_st == 0) begin
      if (mt) begin m_st = 1; m_left = RING; m_snz = MAXS; end
    end else if (!bus.arm_en || bus.stop_btn) begin
      m_st = 0;
    end else if (m_st == 1 && bus.snooze_btn && m_snz > 0) begin
      m_st = 2; m_left = SNZ; m_snz = m_snz - 1;
    end else if (bus.sec_tick) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_st == 1) m_st = 0;
        else begin m_st = 1; m_left = RING; end
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_alarm_out", 32'(bus.alarm_out), 32'(m_st == 1));
    chk("m_state", 32'(bus.state), m_st);
    chk("m_alm_hour", 32'(bus.alm_hour), m_hour);
    chk("m_alm_min", 32'(bus.alm_min), m_min);
    chk("m_snooze_left", 32'(bus.snooze_left), m_snz);
    bus.sec_tick = 1'b0; bus.set_load = 1'b0;
    bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0; rst = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sec_tick = 1'b1;
      cyc();
    end
  endtask

  task automatic match_tick();
    bus.cur_hour = 8'(m_hour); bus.cur_min = 8'(m_min); bus.cur_sec = 8'h00;
    bus.sec_tick = 1'b1;
    cyc();
    bus.cur_sec = 8'h01;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m);
    bus.set_hour = h; bus.set_min = m; bus.set_load = 1'b1;
    cyc();
  endtask

  initial begin
    bus.sec_tick = 0; bus.cur_hour = 8'h12; bus.cur_min = 8'h00; bus.cur_sec = 8'h01;
    bus.set_hour = 0; bus.set_min = 0; bus.set_load = 0; bus.arm_en = 0;
    bus.snooze_btn = 0; bus.stop_btn = 0;
    lt = '{'{8'h24, 8'h5A, 8'h06, 8'h30},
           '{8'h1A, 8'h59, 8'h06, 8'h59},
           '{8'h23, 8'h59, 8'h23, 8'h59},
           '{8'h09, 8'h60, 8'h09, 8'h59},
           '{8'h06, 8'h30, 8'h06, 8'h30}};

    // Reset
    rst = 1'b1;
    cyc();
    chk("rst_alarm_out", 32'(bus.alarm_out), 0);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_alm_hour", 32'(bus.alm_hour), 32'h07);
    chk("rst_alm_min", 32'(bus.alm_min), 32'h00);
    chk("rst_snooze_left", 32'(bus.snooze_left), 3);

    // Load 06:30, arm, ring, timeout after 60 ticks
    bus.arm_en = 1'b1;
    load(8'h06, 8'h30);
    chk("load_hour", 32'(bus.alm_hour), 32'h06);
    chk("load_min", 32'(bus.alm_min), 32'h30);
    match_tick();
    chk("ring_alarm_out", 32'(bus.alarm_out), 1);
    chk("ring_state", 32'(bus.state), 1);
    tick(59);
    chk("ring_59_state", 32'(bus.state), 1);
    tick(1);
    chk("timeout_state", 32'(bus.state), 0);
    chk("timeout_alarm_out", 32'(bus.alarm_out), 0);

    // Three snoozes, fourth ignored
    match_tick();
    for (int k = 0; k < 3; k++) begin
      bus.snooze_btn = 1'b1;
      cyc();
      chk("snz_state", 32'(bus.state), 2);
      chk("snz_alarm_out", 32'(bus.alarm_out), 0);
      chk("snz_left", 32'(bus.snooze_left), 32'(2 - k));
      tick(299);
      chk("snz_299_alarm_out", 32'(bus.alarm_out), 0);
      tick(1);
      chk("snz_end_alarm_out", 32'(bus.alarm_out), 1);
      chk("snz_end_state", 32'(bus.state), 1);
    end
    bus.snooze_btn = 1'b1;
    cyc();
    chk("snz4_state", 32'(bus.state), 1);
    chk("snz4_left", 32'(bus.snooze_left), 0);

    // Recurring match while ringing does not restart the ring period
    tick(30);
    match_tick();
    tick(28);
    chk("norestart_59_state", 32'(bus.state), 1);
    tick(1);
    chk("norestart_end_state", 32'(bus.state), 0);

    // Stop and snooze together: stop wins, snoozes untouched
    match_tick();
    bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1;
    cyc();
    chk("stopsnz_state", 32'(bus.state), 0);
    chk("stopsnz_left", 32'(bus.snooze_left), 3);

    // Load validation table
    for (int i = 0; i < 5; i++) begin
      load(lt[i].h, lt[i].m);
      chk("tbl_hour", 32'(bus.alm_hour), 32'(lt[i].eh));
      chk("tbl_min", 32'(bus.alm_min), 32'(lt[i].em));
    end

    // Disarmed at match time
    bus.arm_en = 1'b0;
    match_tick();
    chk("disarm_alarm_out", 32'(bus.alarm_out), 0);
    bus.arm_en = 1'b1;

    // cur_sec non-zero, and matching time without tick
    bus.cur_hour = 8'h06; bus.cur_min = 8'h30; bus.cur_sec = 8'h01; bus.sec_tick = 1'b1;
    cyc();
    chk("sec01_alarm_out", 32'(bus.alarm_out), 0);
    bus.cur_sec = 8'h00; bus.sec_tick = 1'b0;
    cyc();
    chk("notick_alarm_out", 32'(bus.alarm_out), 0);
    bus.cur_sec = 8'h01;

    // Reset mid-snooze
    match_tick();
    bus.snooze_btn = 1'b1;
    cyc();
    tick(5);
    rst = 1'b1;
    cyc();
    chk("rstsnz_alarm_out", 32'(bus.alarm_out), 0);
    chk("rstsnz_state", 32'(bus.state), 0);
    chk("rstsnz_hour", 32'(bus.alm_hour), 32'h07);
    chk("rstsnz_min", 32'(bus.alm_min), 32'h00);
    chk("rstsnz_left", 32'(bus.snooze_left), 3);

    // Randomized phase against the reference model
    load(8'h06, 8'h30);
    for (int i = 0; i < 8000; i++) begin
      bus.arm_en     = ($urandom_range(0, 599) != 0);
      bus.sec_tick   = $urandom_range(0, 1) != 0;
      bus.cur_hour   = 8'(m_hour);
      bus.cur_min    = 8'(m_min);
      bus.cur_sec    = ($urandom_range(0, 30) == 0) ? 8'h00 : 8'(($urandom_range(1, 5) << 4) | 9);
      bus.snooze_btn = ($urandom_range(0, 40) == 0);
      bus.stop_btn   = ($urandom_range(0, 250) == 0);
      bus.set_load   = ($urandom_range(0, 400) == 0);
      bus.set_hour   = 8'($urandom_range(0, 255));
      bus.set_min    = 8'($urandom_range(0, 255));
      rst            = ($urandom_range(0, 2999) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
